// File: rtl/spi_loader_pkg.sv
// Shared definitions for the SPI configuration-memory loader.
//   MEM_DEPTH_DEFAULT : number of writable configuration bytes
//   CMD_WRITE         : opcode that opens a burst write
//   state_e           : frame-level FSM states
package spi_loader_pkg;

    localparam int unsigned MEM_DEPTH_DEFAULT = 32'd66;
    localparam logic [7:0]  CMD_WRITE         = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_IGNORE = 3'd4
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by an edge register for one asynchronous pin.
//   clk, reset : system clock, synchronous active-high reset
//   din        : asynchronous pin
//   level      : synchronized level
//   rise, fall : one-clk pulses on synchronized 0->1 / 1->0 transitions
// RESET_VAL is the idle level of the pin so that reset does not look like an edge.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain plus the delayed copy used for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
            prev_r <= RESET_VAL;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign level = sync_r;
    assign rise  = sync_r & ~prev_r;
    assign fall  = ~sync_r & prev_r;

endmodule

// File: rtl/spi_mem_loader.sv
// SPI mode-0 front end that turns write frames (opcode, start address, data
// bytes) into single-cycle byte writes into the configuration memory.
//   clk, reset         : system clock, synchronous active-high reset
//   sclk, cs_n, mosi   : SPI pins from the host, asynchronous to clk
//   miso               : echo of the previously received byte, MSB first
//   mem_data, mem_addr : write data/address, held between strobes
//   mem_we             : one-cycle write strobe
//   busy               : frame in progress
//   frame_done         : one-cycle pulse at the end of each frame
//   err                : sticky bad-opcode / out-of-range flag
module spi_mem_loader
    import spi_loader_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] mem_data,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);

    localparam logic [8:0] DEPTH_LIMIT = 9'(MEM_DEPTH);

    // Synchronized pin views
    logic sclk_rise_s, sclk_fall_s, sclk_level_unused_s;
    logic cs_rise_s, cs_fall_s, cs_level_unused_s;
    logic mosi_meta_r, mosi_sync_r;

    // Frame state and datapath
    state_e     state_r, state_next;
    logic [2:0] bit_cnt_r, bit_cnt_next;
    logic [7:0] rx_r, rx_next;
    logic [7:0] tx_r, tx_next;
    logic [7:0] addr_ptr_r, addr_ptr_next;
    logic [1:0] settle_r;
    logic       err_r, err_next;
    logic       mem_we_r, mem_we_next;
    logic [7:0] mem_addr_r, mem_addr_next;
    logic [7:0] mem_data_r, mem_data_next;
    logic       frame_done_r, frame_done_next;
    logic       miso_r, miso_next;
    logic       busy_r;

    logic [7:0] rx_shift_s;
    logic       byte_done_s;
    logic       addr_in_range_s;
    logic       frame_start_s;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sclk),
        .level (sclk_level_unused_s),
        .rise  (sclk_rise_s),
        .fall  (sclk_fall_s)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .din   (cs_n),
        .level (cs_level_unused_s),
        .rise  (cs_rise_s),
        .fall  (cs_fall_s)
    );

    // mosi needs only the two-flop synchronizer, no edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
        end else begin
            mosi_meta_r <= mosi;
            mosi_sync_r <= mosi_meta_r;
        end
    end

    // Settling counter: a cs_n held low across reset produces one synthetic fall
    // while the synchronizer flushes; falls are ignored until the chain has settled.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_r <= 2'd0;
        end else if (settle_r != 2'd3) begin
            settle_r <= settle_r + 2'd1;
        end else begin
            settle_r <= settle_r;
        end
    end

    assign rx_shift_s      = {rx_r[6:0], mosi_sync_r};
    assign byte_done_s     = sclk_rise_s && (bit_cnt_r == 3'd7);
    assign addr_in_range_s = ({1'b0, addr_ptr_r} < DEPTH_LIMIT);
    assign frame_start_s   = cs_fall_s && (settle_r == 2'd3);

    // Next-state and datapath decode for the frame FSM.
    always_comb begin
        state_next      = state_r;
        bit_cnt_next    = bit_cnt_r;
        rx_next         = rx_r;
        tx_next         = tx_r;
        addr_ptr_next   = addr_ptr_r;
        err_next        = err_r;
        mem_we_next     = 1'b0;
        mem_addr_next   = mem_addr_r;
        mem_data_next   = mem_data_r;
        frame_done_next = 1'b0;
        miso_next       = miso_r;

        if (state_r == ST_IDLE) begin
            miso_next = 1'b0;
            if (frame_start_s) begin
                state_next   = ST_CMD;
                bit_cnt_next = 3'd0;
                rx_next      = 8'h00;
                tx_next      = 8'h00;
            end else begin
                state_next = ST_IDLE;
            end
        end else begin
            if (sclk_rise_s) begin
                rx_next      = rx_shift_s;
                bit_cnt_next = bit_cnt_r + 3'd1;
            end else begin
                rx_next = rx_r;
            end

            // Mode 0: present the next echo bit on each falling sclk.
            if (sclk_fall_s) begin
                miso_next = tx_r[7];
                tx_next   = {tx_r[6:0], 1'b0};
            end else begin
                miso_next = miso_r;
            end

            if (byte_done_s) begin
                tx_next = rx_shift_s;
                case (state_r)
                    ST_CMD: begin
                        if (rx_shift_s == CMD_WRITE) begin
                            state_next = ST_ADDR;
                        end else begin
                            state_next = ST_IGNORE;
                            err_next   = 1'b1;
                        end
                    end
                    ST_ADDR: begin
                        addr_ptr_next = rx_shift_s;
                        state_next    = ST_DATA;
                    end
                    ST_DATA: begin
                        if (addr_in_range_s) begin
                            mem_we_next   = 1'b1;
                            mem_addr_next = addr_ptr_r;
                            mem_data_next = rx_shift_s;
                        end else begin
                            err_next = 1'b1;
                        end
                        addr_ptr_next = addr_ptr_r + 8'd1;
                    end
                    ST_IGNORE: begin
                        state_next = ST_IGNORE;
                    end
                    default: begin
                        state_next = ST_IDLE;
                    end
                endcase
            end else begin
                tx_next = tx_next;
            end

            if (state_r == ST_CMD) begin
                miso_next = 1'b0;
            end else begin
                miso_next = miso_next;
            end

            // A byte completing in the same cycle is still processed above.
            if (cs_rise_s) begin
                state_next      = ST_IDLE;
                bit_cnt_next    = 3'd0;
                frame_done_next = 1'b1;
            end else begin
                frame_done_next = 1'b0;
            end
        end
    end

    // Frame state, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 3'd0;
            rx_r         <= 8'h00;
            tx_r         <= 8'h00;
            addr_ptr_r   <= 8'h00;
            err_r        <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= 8'h00;
            mem_data_r   <= 8'h00;
            frame_done_r <= 1'b0;
            miso_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next;
            bit_cnt_r    <= bit_cnt_next;
            rx_r         <= rx_next;
            tx_r         <= tx_next;
            addr_ptr_r   <= addr_ptr_next;
            err_r        <= err_next;
            mem_we_r     <= mem_we_next;
            mem_addr_r   <= mem_addr_next;
            mem_data_r   <= mem_data_next;
            frame_done_r <= frame_done_next;
            miso_r       <= miso_next;
            busy_r       <= (state_next != ST_IDLE);
        end
    end

    assign miso       = miso_r;
    assign mem_data   = mem_data_r;
    assign mem_addr   = mem_addr_r;
    assign mem_we     = mem_we_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign err        = err_r;

endmodule
